// File: rtl/int_long_latency_wb_scheduler.sv
// int_long_latency_wb_scheduler: scoreboard and spare-writeback-port scheduler for the divider and FP-to-int units.
// Revision 1.0
`default_nettype none

module int_long_latency_wb_scheduler #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] i_issue_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_issue_rs2,
  input  logic                        i_issue_uses_rs1,
  input  logic                        i_issue_uses_rs2,
  input  logic [$clog2(NUM_REGS)-1:0] i_issue_rd,
  input  logic                        i_issue_writes_rd,
  input  logic                        i_issue_is_div,
  input  logic                        i_issue_is_fp_long,
  output logic                        o_issue_stall,
  input  logic                        i_div_valid,
  input  logic                        i_fpu_valid,
  input  logic [$clog2(NUM_REGS)-1:0] i_div_rd,
  input  logic [$clog2(NUM_REGS)-1:0] i_fpu_rd,
  input  logic [XLEN-1:0]             i_div_data,
  input  logic [XLEN-1:0]             i_fpu_data,
  output logic                        o_div_ready,
  output logic                        o_fpu_ready,
  input  logic                        i_wb_pipe_valid,
  output logic                        o_wr_en,
  output logic [$clog2(NUM_REGS)-1:0] o_wr_addr,
  output logic [XLEN-1:0]             o_wr_data,
  output logic [NUM_REGS-1:0]         o_busy_mask
);

  localparam int RW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                div_inflight_q, div_inflight_d;
  logic                fpu_inflight_q, fpu_inflight_d;
  logic                rr_last_q, rr_last_d;
  logic                wr_en_q, wr_en_d;
  logic [RW-1:0]       wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]     wr_data_q, wr_data_d;

  logic                issue_accept;
  logic                div_xfer, fpu_xfer;

  // Stall sees only registered state plus issue inputs; no path from unit valids.
  always_comb begin
    o_issue_stall = i_rst_n & i_issue_valid &
                    ((i_issue_uses_rs1  & busy_q[i_issue_rs1]) |
                     (i_issue_uses_rs2  & busy_q[i_issue_rs2]) |
                     (i_issue_writes_rd & busy_q[i_issue_rd])  |
                     (i_issue_is_div     & div_inflight_q)     |
                     (i_issue_is_fp_long & fpu_inflight_q));
    issue_accept  = i_issue_valid & ~o_issue_stall;
  end

  // rr_last_q = 1 means the FPU was granted last, so the divider wins a tie.
  always_comb begin
    o_div_ready = i_rst_n & ~i_wb_pipe_valid & i_div_valid & (~i_fpu_valid | rr_last_q);
    o_fpu_ready = i_rst_n & ~i_wb_pipe_valid & i_fpu_valid & (~i_div_valid | ~rr_last_q);
    div_xfer    = i_div_valid & o_div_ready;
    fpu_xfer    = i_fpu_valid & o_fpu_ready;
  end

  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    rr_last_d      = rr_last_q;
    div_inflight_d = div_inflight_q;
    fpu_inflight_d = fpu_inflight_q;
    busy_d         = busy_q;

    if (div_xfer) begin
      wr_en_d        = (i_div_rd != '0);
      wr_addr_d      = i_div_rd;
      wr_data_d      = i_div_data;
      rr_last_d      = 1'b0;
      div_inflight_d = 1'b0;
    end else if (fpu_xfer) begin
      wr_en_d        = (i_fpu_rd != '0);
      wr_addr_d      = i_fpu_rd;
      wr_data_d      = i_fpu_data;
      rr_last_d      = 1'b1;
      fpu_inflight_d = 1'b0;
    end

    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end

    // Set after clear so a newly issued owner keeps the bit.
    if (issue_accept) begin
      if (i_issue_is_div) begin
        div_inflight_d = 1'b1;
      end
      if (i_issue_is_fp_long) begin
        fpu_inflight_d = 1'b1;
      end
      if ((i_issue_is_div | i_issue_is_fp_long) & i_issue_writes_rd) begin
        busy_d[i_issue_rd] = 1'b1;
      end
    end

    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q         <= '0;
      div_inflight_q <= 1'b0;
      fpu_inflight_q <= 1'b0;
      rr_last_q      <= 1'b1;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      busy_q         <= busy_d;
      div_inflight_q <= div_inflight_d;
      fpu_inflight_q <= fpu_inflight_d;
      rr_last_q      <= rr_last_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy_mask = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_int_long_latency_wb_scheduler.sv
// Testbench for int_long_latency_wb_scheduler: directed scenarios with a write-port scoreboard.
// Revision 1.0
`default_nettype none

module tb_int_long_latency_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, uses_rs1, uses_rs2, writes_rd, is_div, is_fp;
  logic [4:0]  rs1, rs2, rd;
  logic        stall;
  logic        div_valid, fpu_valid, div_ready, fpu_ready, wb_pipe;
  logic [4:0]  div_rd, fpu_rd;
  logic [31:0] div_data, fpu_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  int n_vec  = 0;
  int n_miss = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  int_long_latency_wb_scheduler #(.XLEN(32), .NUM_REGS(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_issue_valid(issue_valid), .i_issue_rs1(rs1), .i_issue_rs2(rs2),
    .i_issue_uses_rs1(uses_rs1), .i_issue_uses_rs2(uses_rs2),
    .i_issue_rd(rd), .i_issue_writes_rd(writes_rd),
    .i_issue_is_div(is_div), .i_issue_is_fp_long(is_fp),
    .o_issue_stall(stall),
    .i_div_valid(div_valid), .i_fpu_valid(fpu_valid),
    .i_div_rd(div_rd), .i_fpu_rd(fpu_rd),
    .i_div_data(div_data), .i_fpu_data(fpu_data),
    .o_div_ready(div_ready), .o_fpu_ready(fpu_ready),
    .i_wb_pipe_valid(wb_pipe),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy_mask(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every regfile write the DUT produces must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {27'd0, wr_addr, wr_data}, 64'd0);
      end else begin
        chk("wr_port", {27'd0, wr_addr, wr_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_issue();
    issue_valid = 0; uses_rs1 = 0; uses_rs2 = 0; writes_rd = 0;
    is_div = 0; is_fp = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic set_issue(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                           input logic u2, input logic [4:0] d, input logic w,
                           input logic dv, input logic fp);
    issue_valid = 1; rs1 = r1; uses_rs1 = u1; rs2 = r2; uses_rs2 = u2;
    rd = d; writes_rd = w; is_div = dv; is_fp = fp;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    settle();
  endtask

  initial begin
    rst_n = 0; wb_pipe = 0;
    div_valid = 0; fpu_valid = 0; div_rd = 0; fpu_rd = 0; div_data = 0; fpu_data = 0;
    clr_issue();

    // Reset state: outputs zero, combinational outputs gated.
    set_issue(5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 0);
    div_valid = 1; div_rd = 5'd3;
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_div_ready", div_ready, 0);
    chk("rst_outs", {wr_en, wr_addr, wr_data, busy}, 0);
    div_valid = 0; div_rd = 0;
    clr_issue();
    tick();
    rst_n = 1;
    settle();

    // RAW: divide to x5 then ADD x6,x5,x1.
    set_issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);
    settle();
    chk("div5_issue_stall", stall, 0);
    tick();
    chk("busy5_set", busy, 32'h20);
    set_issue(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    settle();
    chk("raw_stall_0", stall, 1);
    tick();
    chk("raw_stall_1", stall, 1);
    div_valid = 1; div_rd = 5'd5; div_data = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    settle();
    chk("div5_ready", div_ready, 1);
    chk("raw_stall_2", stall, 1);
    tick();
    div_valid = 0;
    chk("div5_wr_en", wr_en, 1);
    chk("raw_stall_wr", stall, 1);
    tick();
    chk("raw_stall_release", stall, 0);
    chk("busy5_clear", busy, 0);
    tick();
    clr_issue();

    // Tie out of reset: divider first, then FPU.
    do_reset();
    div_valid = 1; div_rd = 5'd3; div_data = 32'h11;
    fpu_valid = 1; fpu_rd = 5'd4; fpu_data = 32'h22;
    exp_q.push_back({5'd3, 32'h11});
    exp_q.push_back({5'd4, 32'h22});
    settle();
    chk("tie_readies", {div_ready, fpu_ready}, 2'b10);
    tick();
    div_valid = 0;
    settle();
    chk("tie_fpu_ready", fpu_ready, 1);
    chk("tie_wr_first", {wr_en, wr_addr}, {1'b1, 5'd3});
    tick();
    fpu_valid = 0;
    chk("tie_wr_second", {wr_en, wr_addr}, {1'b1, 5'd4});
    tick();

    // Main pipeline owns the port for 3 cycles.
    wb_pipe = 1;
    div_valid = 1; div_rd = 5'd9;  div_data = 32'h99;
    fpu_valid = 1; fpu_rd = 5'd10; fpu_data = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wbp_readies", {div_ready, fpu_ready}, 2'b00);
      tick();
      chk("wbp_hold", {wr_en, wr_addr, wr_data}, {1'b0, 5'd4, 32'h22});
    end
    wb_pipe = 0;
    exp_q.push_back({5'd9, 32'h99});
    exp_q.push_back({5'd10, 32'hAA});
    settle();
    chk("wbp_div_first", {div_ready, fpu_ready}, 2'b10);
    tick();
    div_valid = 0;
    tick();
    fpu_valid = 0;
    tick();

    // Divide to x0: handshake but no write, no busy.
    set_issue(5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);
    tick();
    clr_issue();
    chk("x0_busy", busy, 0);
    set_issue(5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0);
    settle();
    chk("div_inflight_stall", stall, 1);
    clr_issue();
    div_valid = 1; div_rd = 5'd0; div_data = 32'h55;
    settle();
    chk("x0_ready", div_ready, 1);
    tick();
    div_valid = 0;
    chk("x0_no_wr", wr_en, 0);
    chk("x0_busy_after", busy, 0);
    set_issue(5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 0);
    settle();
    chk("div8_accept", stall, 0);
    tick();
    clr_issue();
    chk("busy8", busy, 32'h100);
    div_valid = 1; div_rd = 5'd8; div_data = 32'h88;
    exp_q.push_back({5'd8, 32'h88});
    tick();
    div_valid = 0;
    tick();
    chk("busy8_clear", busy, 0);

    // WAW: FPU to x7 in flight, then divide to x7.
    set_issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 1);
    tick();
    chk("busy7", busy, 32'h80);
    set_issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);
    settle();
    chk("waw_stall", stall, 1);
    fpu_valid = 1; fpu_rd = 5'd7; fpu_data = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    settle();
    chk("waw_stall_xfer", stall, 1);
    tick();
    fpu_valid = 0;
    chk("waw_stall_wr", stall, 1);
    tick();
    chk("waw_release", stall, 0);
    tick();
    clr_issue();
    chk("busy7_reset_by_div", busy, 32'h80);

    // Async reset with busy = 0xA0 and divider in flight.
    set_issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 1);
    tick();
    clr_issue();
    chk("busy_a0", busy, 32'hA0);
    #2;
    rst_n = 0;
    set_issue(5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 0);
    #1;
    chk("async_rst_outs", {wr_en, wr_addr, wr_data, busy}, 0);
    chk("async_rst_stall", stall, 0);
    tick();
    rst_n = 1;
    settle();
    chk("post_rst_div_accept", stall, 0);
    tick();
    clr_issue();
    chk("post_rst_busy3", busy, 32'h8);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/int_long_latency_wb_scheduler.md
# int_long_latency_wb_scheduler

Scoreboard and writeback scheduler for integer results from the two multi-cycle units: the integer divider and the long-latency FP-to-int path. It tracks which integer registers have results still in flight and stalls issue on RAW or WAW hazards that the forwarding network cannot cover. It also arbitrates the single spare integer regfile write port between the two units, giving way to the main pipeline WB write. It sits beside the hazard logic in the control block and feeds a stall term into the pipeline control bundle.

## Interface
- XLEN, 32, data width
- NUM_REGS, 32, integer register count; register index width is $clog2(NUM_REGS)

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_issue_valid  in  1  an instruction leaves ID for EX this cycle; the pipeline is unstalled apart from this block
- i_issue_rs1, i_issue_rs2  in  5 each  source registers of the issuing instruction
- i_issue_uses_rs1, i_issue_uses_rs2  in  1 each  the source is actually read
- i_issue_rd  in  5  destination register
- i_issue_writes_rd  in  1  the instruction writes the integer regfile
- i_issue_is_div, i_issue_is_fp_long  in  1 each  target unit, one-hot or zero
- o_issue_stall  out  1  combinational; hold the issuing instruction in ID
- i_div_valid, i_fpu_valid  in  1 each  unit result pending
- i_div_rd, i_fpu_rd  in  5 each  result destination
- i_div_data, i_fpu_data  in  XLEN each  result value
- o_div_ready, o_fpu_ready  out  1 each  combinational grant
- i_wb_pipe_valid  in  1  main pipeline WB owns the regfile write port this cycle
- o_wr_en  out  1  registered write enable for the spare regfile port
- o_wr_addr  out  5  registered write address
- o_wr_data  out  XLEN  registered write data
- o_busy_mask  out  NUM_REGS  registered scoreboard; bit r set means register r is pending

## Operation
- State: busy[NUM_REGS-1:0], div_inflight, fpu_inflight, rr_last (0 = div granted last), and the three output registers.
- The stall rule: o_issue_stall = i_issue_valid and any of the following:
  - uses_rs1 and busy[rs1]
  - uses_rs2 and busy[rs2]
  - writes_rd and busy[rd], which is the WAW case
  - is_div and div_inflight
  - is_fp_long and fpu_inflight
- Register index 0 never counts as busy.
- Accepted issue is i_issue_valid and not o_issue_stall. An accepted issue has these effects:
  - is_div sets div_inflight.
  - is_fp_long sets fpu_inflight.
  - If the instruction targets a unit and writes_rd with rd != 0, busy[rd] is set.
- Arbitration happens only when i_wb_pipe_valid = 0:
  - If exactly one unit is valid, it is granted.
  - If both are valid, the unit not equal to rr_last is granted.
  - If i_wb_pipe_valid = 1, there is no grant and both readies are 0.
- Handshake: each unit holds valid, rd and data stable until ready. A transfer completes on a cycle where valid and ready are both 1.
- On a transfer:
  - o_wr_en <= (rd != 0), o_wr_addr <= rd, o_wr_data <= data.
  - rr_last updates to the granted unit.
  - The unit's inflight flag clears.
- On a cycle with no transfer, o_wr_en <= 0. o_wr_addr and o_wr_data hold their values.
- busy[o_wr_addr] clears on the edge that ends a cycle with o_wr_en = 1, which is the same edge at which the regfile commits the write.
- Simultaneous set and clear of the same busy bit: set wins, because the new owner has issued.
- rd = 0 results: the unit still occupies itself and still handshakes, but no regfile write happens and no busy bit changes.

## Timing
- Reset values while i_rst_n = 0, applied asynchronously:
  - busy = 0, div_inflight = fpu_inflight = 0, rr_last = 1 so the divider wins the first tie.
  - o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0, o_busy_mask = 0.
  - o_issue_stall and both readies are forced to 0.
- Reset mid-operation discards all pending state. Results that units present after reset are still granted and written, but they set no busy bits.
- Grant to regfile write: 1 cycle. Transfer at edge N drives o_wr_en during cycle N+1. The regfile write and the busy clear both happen at edge N+2. A dependent instruction can issue in cycle N+2 and reads the committed value from the regfile.
- Issue to busy visible: an accepted issue at edge N makes busy and o_issue_stall visible in cycle N+1.
- Timing paths:
  - o_issue_stall uses only registered busy and inflight bits plus issue inputs; it has no path from the unit valids.
  - Readies depend only on the unit valids, i_wb_pipe_valid and rr_last.

## Test plan
- Divide to x5, then ADD x6,x5,x1 issued next cycle.
  - o_issue_stall stays 1 until the cycle after o_wr_en=1 with o_wr_addr=5.
  - It then drops, and o_busy_mask[5]=0.
- Divider (rd=3, data 0x11) and FPU (rd=4, data 0x22) valid in the same cycle out of reset.
  - The divider is granted first, then the FPU on the next cycle.
  - Writes appear on back-to-back cycles, 3/0x11 then 4/0x22.
- Both units valid with i_wb_pipe_valid=1 for 3 cycles: both readies are 0 for 3 cycles, o_wr_en=0, and data is held. The divider is granted in cycle 4.
- Divide to x0:
  - The handshake completes and o_wr_en stays 0.
  - o_busy_mask stays 0.
  - A second divide issued afterwards is accepted once div_inflight clears.
- WAW: FPU op to x7 in flight, then a divide to x7 is issued. The issue stalls until the FPU write commits. The divide is then accepted and busy[7] is set again.
- Assert i_rst_n=0 with busy=0x0000_00A0 and div_inflight=1. All outputs reach their reset values immediately, and the next issue to the divider is accepted without stall.
